ps2_scancode_rx: RTL
====================

// Module: ps2_scancode_rx
// PURPOSE
//  Receives PS/2 keyboard frames on the raw PS2Clk/PS2Data lines and delivers
//  each byte (make code, 0xF0 break prefix, extended prefix) as Keycode plus
//  a one-Clock Enable strobe. This is the producing end of the Keycode/Enable
//  interface consumed by SoundSM. Bad frames are dropped and flagged.
// PARAMETERS
//  FILTER_LEN      8       consecutive equal samples needed to accept a PS2Clk level
//  TIMEOUT_CYCLES  100000  Clock cycles without a PS2Clk falling edge mid-frame before abort
// PORTS
//  Clock      in   1  system clock (100 MHz nominal)
//  Reset      in   1  asynchronous, active-high reset
//  PS2Clk     in   1  raw PS/2 clock, asynchronous to Clock
//  PS2Data    in   1  raw PS/2 data, asynchronous to Clock
//  Keycode    out  8  last correctly received byte; held until next good frame
//  Enable     out  1  one-cycle strobe: Keycode is newly valid
//  ParityErr  out  1  one-cycle strobe: frame dropped, odd parity failed
//  FrameErr   out  1  one-cycle strobe: frame dropped, bad stop bit or timeout
// BEHAVIOUR
//  Reset (async): Keycode=0x00, Enable=ParityErr=FrameErr=0, state IDLE,
//   bit count 0, shift reg 0, timeout count 0, filtered clock=1, sync FFs=1.
//  Input path: PS2Clk and PS2Data each pass a 2-FF synchroniser.
//   Filter: filtered clock takes the synced level after FILTER_LEN consecutive
//   equal samples; shorter glitches are ignored.
//   Fall = filtered clock 1->0 this cycle; synced PS2Data is sampled that cycle.
//  Frame: start(0), D0..D7 LSB first, parity (odd over D0..D7+P), stop(1).
//  FSM:
//   IDLE : on Fall with data=0 -> SHIFT, bitcnt=0, timeout cleared.
//          Fall with data=1 ignored (stay IDLE, no flag).
//   SHIFT: each Fall stores the sampled bit; bitcnt 0..7 data, 8 parity,
//          9 stop. After the stop bit is sampled -> CHECK.
//          Timeout count increments each cycle, clears on Fall; on reaching
//          TIMEOUT_CYCLES -> IDLE, FrameErr=1 for one cycle, data discarded.
//   CHECK: single cycle, then always -> IDLE.
//          stop=0            -> FrameErr pulse (takes priority over parity).
//          parity even       -> ParityErr pulse.
//          else              -> Keycode<=D[7:0], Enable pulse.
//  Latency: Enable, ParityErr and FrameErr (stop-bit case) rise the cycle after
//   CHECK is entered, i.e. 2 Clock cycles after the Fall that samples the stop
//   bit. Keycode changes in the same cycle Enable rises.
//  At most one of Enable/ParityErr/FrameErr is high in any cycle; each is high
//   exactly one cycle per event.
//  Repeated bytes (e.g. 0x15 twice) each produce their own Enable.
//  A Fall during CHECK is ignored. Device-side inhibit (PS2Clk held low) in
//   SHIFT ends in a timeout. Keycode is not cleared by errors or timeouts.
//  Reset mid-frame: immediate return to reset values; partial frame lost.
//  Receive only: never drives PS2Clk or PS2Data.
// TESTING (bench: PS/2 half-period 200 Clock cycles, TIMEOUT_CYCLES=1000)
//  1 Send 0x15 (data 1,0,1,0,1,0,0,0; P=0; stop=1) -> Keycode=0x15; Enable high
//    exactly 1 cycle, 2 cycles after the stop-bit Fall; no error strobes.
//  2 Send 0xF0 (P=1), then 0x15 -> two Enable pulses with Keycode 0xF0, then
//    0x15; stream 0x15,0xF0,0x15,0x00,0x15,0xF0,0x15 gives 7 Enables in order.
//  3 Send 0x15 with P=1 -> ParityErr 1 cycle; no Enable; Keycode unchanged.
//    Send 0x15 with stop=0 -> FrameErr 1 cycle only.
//  4 Send start + 4 data bits, then hold PS2Clk high -> FrameErr 1000 cycles
//    after the last Fall; next full 0x15 frame gives a normal Enable.
//  5 Inject a 3-cycle low glitch on PS2Clk mid-frame -> no extra bit; frame
//    decodes correctly. Assert Reset after 6 bits -> outputs return to reset
//    values at once; next frame 0x1C -> Keycode=0x1C with Enable.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches PS2Clk, shifts in 11-bit
// frames and emits each good byte as Keycode with a one-cycle Enable strobe.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic [7:0] Keycode,
    output logic       Enable,
    output logic       ParityErr,
    output logic       FrameErr
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic          filt_clk_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic [1:0]    state_reg;
    logic [3:0]    bitcnt_reg;
    logic [9:0]    shift_reg;
    logic [TW-1:0] timeout_reg;
    logic [7:0]    keycode_reg;
    logic          enable_reg;
    logic          parity_err_reg;
    logic          frame_err_reg;

    logic clk_s;
    logic data_s;
    logic filt_flip;
    logic fall;

    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];

    // The filtered clock only follows the synced line once it has disagreed
    // for FILTER_LEN consecutive samples, so short glitches never reach the FSM.
    assign filt_flip = (clk_s != filt_clk_reg) && (filt_cnt_reg == FW'(FILTER_LEN - 1));
    assign fall      = filt_flip && filt_clk_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_sync_reg   <= 2'b11;
            data_sync_reg  <= 2'b11;
            filt_clk_reg   <= 1'b1;
            filt_cnt_reg   <= '0;
            state_reg      <= IDLE;
            bitcnt_reg     <= 4'd0;
            shift_reg      <= 10'd0;
            timeout_reg    <= '0;
            keycode_reg    <= 8'h00;
            enable_reg     <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], PS2Clk};
            data_sync_reg <= {data_sync_reg[0], PS2Data};

            if (clk_s == filt_clk_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_flip) begin
                filt_clk_reg <= clk_s;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + FW'(1);
            end

            enable_reg     <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (fall && !data_s) begin
                        state_reg   <= SHIFT;
                        bitcnt_reg  <= 4'd0;
                        timeout_reg <= '0;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        // After ten shifts: [7:0] = D7..D0, [8] = parity, [9] = stop.
                        shift_reg   <= {data_s, shift_reg[9:1]};
                        bitcnt_reg  <= bitcnt_reg + 4'd1;
                        timeout_reg <= '0;
                        if (bitcnt_reg == 4'd9) begin
                            state_reg <= CHECK;
                        end
                    end else if (timeout_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_reg     <= IDLE;
                        bitcnt_reg    <= 4'd0;
                        timeout_reg   <= '0;
                        frame_err_reg <= 1'b1;
                    end else begin
                        timeout_reg <= timeout_reg + TW'(1);
                    end
                end
                CHECK: begin
                    state_reg <= IDLE;
                    if (!shift_reg[9]) begin
                        frame_err_reg <= 1'b1;
                    end else if (!(^shift_reg[8:0])) begin
                        parity_err_reg <= 1'b1;
                    end else begin
                        keycode_reg <= shift_reg[7:0];
                        enable_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Keycode   = keycode_reg;
    assign Enable    = enable_reg;
    assign ParityErr = parity_err_reg;
    assign FrameErr  = frame_err_reg;

endmodule
